pwm_capture: RTL and testbench
==============================

# pwm_capture

Receive-side counterpart of the PWM/pulse-density DAC output: it recovers a `PWM_BITS`-wide sample from a 1-bit pulse stream by counting high cycles over a free-running window of N = 2^PWM_BITS clocks. The input is synchronised and glitch-filtered. Each completed window yields one sample, delivered over a valid/ready handshake. The block sits at the pad/comparator input feeding the sample-processing path, and also serves as the loopback checker for the PWM output.

## Interface
- `PWM_BITS`, 10, sample width; window length N = 2^PWM_BITS clocks
- `SYNC_STAGES`, 2, input synchroniser depth (≥2)
- `FILT_LEN`, 3, glitch-filter run length (≥1; 1 = filter bypassed)
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pwm_in`  in  1  asynchronous pulse-stream input
- `enable`  in  1  window counting enable
- `adc_val`  out  PWM_BITS  recovered sample
- `val_valid`  out  1  `adc_val` holds an untaken sample
- `val_ready`  in  1  consumer accepts sample
- `overrun`  out  1  sticky: a pending sample was overwritten
- `ovr_clr`  in  1  clears `overrun`

## Operation
- **Synchroniser:** `pwm_in` passes through `SYNC_STAGES` flops, each reset to 0.
- **Glitch filter:** registered `filt_q` (reset 0) takes value v when the newest `FILT_LEN` synchroniser outputs all equal v; otherwise it holds.
- **Pipeline latency:** `pwm_in` to `filt_q` is exactly `SYNC_STAGES + FILT_LEN` cycles. With defaults this is 5.
- **Window counter:** `win_cnt`, PWM_BITS wide, counts 0..N-1 and wraps. Each cycle the accumulator `acc` (PWM_BITS+1 bits) adds `filt_q`.
- **Window end:** on the cycle `win_cnt == N-1`:
  - total = `acc + filt_q`;
  - `adc_val` <= min(total, N-1), i.e. a full window of highs saturates to N-1;
  - `acc` <= 0;
  - `val_valid` <= 1.
- **Handshake:**
  - A transfer occurs when `val_valid && val_ready`. After a transfer `val_valid` drops unless a new result loads in the same cycle; if one does, `val_valid` stays 1 and `overrun` is not set.
  - If a new result arrives while `val_valid=1 && !val_ready`, `adc_val` is overwritten, `val_valid` stays 1, and `overrun` is set.
- **Overrun clear:** `ovr_clr` clears `overrun`. If a set and `ovr_clr` occur in the same cycle, set wins.
- **Enable:**
  - `enable=0` holds `win_cnt` and `acc` at 0 and produces no results.
  - `adc_val`, `val_valid`, `overrun` and the handshake keep working while disabled.
  - Synchroniser and filter always run.
  - When `enable` rises, a fresh window starts at `win_cnt=0`.
- **Reset:** asserting `rst_n` mid-window discards the partial count. After release, counting restarts at `win_cnt=0`.

## Timing
- Reset values: `adc_val=0`, `val_valid=0`, `overrun=0`, `win_cnt=0`, `acc=0`, `filt_q=0`, sync flops 0.
- First result after reset release (with `enable=1`): `val_valid` rises on clock edge N.
- With `enable` continuously high, results then arrive every N cycles.
- `adc_val` and `val_valid` update on the same edge. All outputs are registered; there is no combinational path from `val_ready` to any output.
- The first window includes the pipeline fill, so ones present at the pin during that window are under-counted by up to `SYNC_STAGES + FILT_LEN`.
- `pwm_in` is asynchronous to `clk`; only the synchroniser samples it.

## Structure
- **Shared PWM package:** holds `PWM_BITS` default, the N derivation, and the saturating-count helper. The PWM output block uses the same package.
- **Sub-module `sync_glitch_filter`:** synchroniser plus run-length filter, parameterised by `SYNC_STAGES` and `FILT_LEN`. The remaining logic (window counter, accumulator, output/handshake register) stays in `pwm_capture`.

## Test plan
- **Constant high:** `pwm_in=1`, `enable=1`, `val_ready=1`, defaults → first `adc_val=1019`, then 1023 (saturated) every 1024 cycles.
- **50% square:** period-2 square wave, after the first window → `adc_val=512` every window. Period-8 wave with 3 cycles high → 384.
- **Glitch rejection:** low input with 1- and 2-cycle high pulses → `adc_val=0`. A single clean 10-cycle pulse (`FILT_LEN=3`) → 10.
- **Backpressure and overrun:**
  - `val_ready=0` across 2 window ends → `overrun=1`, `adc_val` holds the second result, `val_valid` stays 1.
  - `ovr_clr` pulsed on the same cycle as a third window end → `overrun` stays 1.
  - `ovr_clr` on a later cycle → `overrun=0`.
- **Reset and enable mid-window:**
  - `rst_n` low at `win_cnt=500` → all outputs 0; next `val_valid` exactly 1024 cycles after release.
  - `enable` low for 300 cycles → no result while disabled; next result 1024 cycles after `enable` rises.
- **Loopback:** PWM output block with `dac_val=300`, `FILT_LEN=1` → after settling, `adc_val` within ±1 of 300 for every window.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared PWM definitions: default sample width, window length derivation and the
// saturating count helper used by both the PWM output and capture blocks.
package pwm_capture_pkg;

  localparam int unsigned PwmBitsDefault = 10;

  function automatic int unsigned pwm_window_len(int unsigned bits);
    return 32'd1 << bits;
  endfunction

  // Clamp a window total to the largest representable sample (N-1).
  function automatic int unsigned sat_count(int unsigned total, int unsigned bits);
    int unsigned max_val;
    max_val = pwm_window_len(bits) - 1;
    return (total > max_val) ? max_val : total;
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// Input synchroniser followed by a run-length glitch filter; pwm_in to filt
// latency is SYNC_STAGES + FILT_LEN cycles.
module sync_glitch_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt
);

  // Synchroniser flops followed by FILT_LEN-1 history flops in one shift chain.
  localparam int unsigned Depth = SYNC_STAGES + FILT_LEN - 1;

  logic [Depth-1:0]    shift_q;
  logic [FILT_LEN-1:0] run;
  logic                filt_d, filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      filt_q  <= 1'b0;
    end else begin
      shift_q <= {shift_q[Depth-2:0], din};
      filt_q  <= filt_d;
    end
  end

  // Newest FILT_LEN synchroniser outputs, starting at the last synchroniser stage.
  assign run = shift_q[Depth-1 -: FILT_LEN];

  always_comb begin
    filt_d = filt_q;
    if (&run) begin
      filt_d = 1'b1;
    end else if (~|run) begin
      filt_d = 1'b0;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/pwm_capture.sv
// Recovers a PWM_BITS-wide sample from a pulse stream by counting filtered high
// cycles over a free-running 2^PWM_BITS window; samples leave over valid/ready.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned PWM_BITS    = PwmBitsDefault,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_in,
  input  logic                enable,
  output logic [PWM_BITS-1:0] adc_val,
  output logic                val_valid,
  input  logic                val_ready,
  output logic                overrun,
  input  logic                ovr_clr
);

  localparam int unsigned N = pwm_window_len(PWM_BITS);
  localparam logic [PWM_BITS-1:0] WinLast = PWM_BITS'(N - 1);

  logic                filt;
  logic [PWM_BITS-1:0] win_cnt_d, win_cnt_q;
  logic [PWM_BITS:0]   acc_d, acc_q, total;
  logic [PWM_BITS-1:0] adc_val_d, adc_val_q;
  logic                val_valid_d, val_valid_q;
  logic                overrun_d, overrun_q;
  logic                load, xfer;

  sync_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pwm_in),
    .filt (filt)
  );

  always_comb begin
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    adc_val_d   = adc_val_q;
    val_valid_d = val_valid_q;
    overrun_d   = overrun_q;

    total = acc_q + (PWM_BITS + 1)'(filt);
    load  = enable && (win_cnt_q == WinLast);
    xfer  = val_valid_q && val_ready;

    if (!enable) begin
      win_cnt_d = '0;
      acc_d     = '0;
    end else begin
      win_cnt_d = win_cnt_q + PWM_BITS'(1);
      acc_d     = load ? '0 : total;
    end

    if (load) begin
      adc_val_d   = PWM_BITS'(sat_count(32'(total), PWM_BITS));
      val_valid_d = 1'b1;
    end else if (xfer) begin
      val_valid_d = 1'b0;
    end

    // A simultaneous transfer frees the slot, so only an untaken sample overruns.
    if (load && val_valid_q && !val_ready) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= '0;
      acc_q       <= '0;
      adc_val_q   <= '0;
      val_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      adc_val_q   <= adc_val_d;
      val_valid_q <= val_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign adc_val   = adc_val_q;
  assign val_valid = val_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: default instance plus a FILT_LEN=1 instance fed
// by a square wave or a PWM loopback stream.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0, enable = 1'b0, val_ready = 1'b0, ovr_clr = 1'b0;
  logic [9:0] adc_val;
  logic       val_valid, overrun;

  logic       pwm_in1 = 1'b0, enable1 = 1'b1, val_ready1 = 1'b1, ovr_clr1 = 1'b0;
  logic [9:0] adc_val1;
  logic       val_valid1, overrun1;

  int          checks = 0;
  int          failures = 0;
  int          mode = 0;   // stimulus for the default instance
  int          mode1 = 0;  // 0: period-2 square, 1: PWM of 300/1024
  int unsigned gcnt = 0;
  int          c, seen;

  always #5 clk = ~clk;

  pwm_capture u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .enable   (enable),
    .adc_val  (adc_val),
    .val_valid(val_valid),
    .val_ready(val_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  pwm_capture #(
    .PWM_BITS   (10),
    .SYNC_STAGES(2),
    .FILT_LEN   (1)
  ) u_dut_nf (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in1),
    .enable   (enable1),
    .adc_val  (adc_val1),
    .val_valid(val_valid1),
    .val_ready(val_ready1),
    .overrun  (overrun1),
    .ovr_clr  (ovr_clr1)
  );

  task automatic check_eq(string tag, int unsigned obs, int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  // Negedges until val_valid is seen, bounded.
  task automatic next_result(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!val_valid && cyc < 3000);
  endtask

  // Pattern generator, phase counter restarts during reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) gcnt = 0;
      else        gcnt++;
      case (mode)
        1:       pwm_in = 1'b1;
        3:       pwm_in = (gcnt % 8) < 3;
        4:       pwm_in = ((gcnt % 16) == 0) || ((gcnt % 16) == 5) || ((gcnt % 16) == 6);
        5:       pwm_in = ((gcnt % 1024) >= 100) && ((gcnt % 1024) < 110);
        default: pwm_in = 1'b0;
      endcase
      pwm_in1 = (mode1 == 0) ? gcnt[0] : ((gcnt % 1024) < 300);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and constant high.
    mode = 1; enable = 1'b1; val_ready = 1'b1;
    cycles(2);
    check_eq("rst_adc", adc_val, 0);
    check_eq("rst_valid", val_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    next_result(c);
    check_eq("hi_latency", c, 1024);
    check_eq("hi_first", adc_val, 1019);
    next_result(c);
    check_eq("hi_period", c, 1024);
    check_eq("hi_sat", adc_val, 1023);
    next_result(c);
    check_eq("hi_sat2", adc_val, 1023);

    // Period-8 3-high on default instance, period-2 square on unfiltered one.
    mode = 3; mode1 = 0;
    do_reset();
    next_result(c);
    for (int i = 0; i < 2; i++) begin
      next_result(c);
      check_eq("duty_3of8", adc_val, 384);
      check_eq("square_valid", val_valid1, 1);
      check_eq("square_50", adc_val1, 512);
    end

    // Short glitches are rejected.
    mode = 4;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      next_result(c);
      check_eq("glitch", adc_val, 0);
    end

    // One clean 10-cycle pulse per window.
    mode = 5;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      next_result(c);
      check_eq("pulse10", adc_val, 10);
    end

    // Backpressure and overrun.
    mode = 1; val_ready = 1'b0;
    do_reset();
    cycles(1024);
    check_eq("bp_valid1", val_valid, 1);
    check_eq("bp_adc1", adc_val, 1019);
    check_eq("bp_ovr1", overrun, 0);
    cycles(1024);
    check_eq("bp_valid2", val_valid, 1);
    check_eq("bp_adc2", adc_val, 1023);
    check_eq("bp_ovr2", overrun, 1);
    cycles(1023);
    ovr_clr = 1'b1;
    cycles(1);
    ovr_clr = 1'b0;
    check_eq("bp_set_wins", overrun, 1);
    cycles(1);
    ovr_clr = 1'b1;
    cycles(1);
    ovr_clr = 1'b0;
    check_eq("bp_clr", overrun, 0);
    check_eq("bp_valid_hold", val_valid, 1);
    cycles(1021);
    val_ready = 1'b1;
    cycles(1);
    check_eq("xfer_load_valid", val_valid, 1);
    check_eq("xfer_load_ovr", overrun, 0);
    cycles(1);
    check_eq("xfer_drop", val_valid, 0);

    // Reset mid-window discards the partial count.
    val_ready = 1'b0;
    do_reset();
    cycles(1024);
    check_eq("mr_valid_pre", val_valid, 1);
    cycles(500);
    rst_n = 1'b0;
    #1;
    check_eq("mr_adc", adc_val, 0);
    check_eq("mr_valid", val_valid, 0);
    check_eq("mr_ovr", overrun, 0);
    val_ready = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    next_result(c);
    check_eq("mr_latency", c, 1024);
    check_eq("mr_adc_post", adc_val, 1019);

    // Enable low across a would-be window end.
    do_reset();
    next_result(c);
    cycles(876);
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (val_valid) seen++;
    end
    check_eq("dis_no_result", seen, 0);
    enable = 1'b1;
    next_result(c);
    check_eq("en_latency", c, 1024);
    check_eq("en_adc", adc_val, 1023);

    // Loopback of a 300/1024 PWM stream into the unfiltered instance.
    mode1 = 1;
    do_reset();
    next_result(c);
    for (int i = 0; i < 2; i++) begin
      next_result(c);
      check_eq("loop_valid", val_valid1, 1);
      check_eq("loop_300", (adc_val1 inside {[299:301]}) ? 300 : adc_val1, 300);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
